// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences each instruction
// through its phases and drives datapath enables plus the ALU op class (ALUOp1/ALUOp0/AluOpcode).
// Latency: outputs are registered from the next state, so they change on the clock edge that enters a state.
// Backpressure: none by default. With MCC_MEM_WAIT_EN defined, the FSM holds FETCH, MEMRD and MEMWR while
// MemReady=0. In that wait, PCWrite, IRWrite, MemWrite and InstrDone are masked, and MemRead stays high.
// Ports: clk, reset (async, active-high), Opcode (IR[31:26]), [MemReady], datapath enables,
//        ALUSrcA/ALUSrcB/PCSource muxes, ALUOp1/ALUOp0/AluOpcode, InstrDone pulse, sticky Trap.
// Optional feature macro: MCC_MEM_WAIT_EN (adds the MemReady handshake).
module multicycle_main_control #(
  parameter int STATE_W         = 4,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
`ifdef MCC_MEM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic [5:0] AluOpcode,
  output logic       InstrDone,
  output logic       Trap
);

  typedef enum logic [STATE_W-1:0] {
    RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, RWB, BRANCH, JUMP, EXEC_I, IWB, ILLEGAL
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  state_t state, nxt;
  logic   mem_ready;

`ifdef MCC_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  // Registered versions of the enables that must be masked during a memory wait.
  logic pcwrite_q, irwrite_q, memwrite_q, instrdone_q;

  // Next-state decode.
  always_comb begin
    nxt = RST;
    case (state)
      RST:     nxt = FETCH;
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:                      nxt = MEMADR;
          OP_R:                              nxt = EXEC_R;
          OP_BEQ:                            nxt = BRANCH;
          OP_J:                              nxt = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = EXEC_I;
          default:                           nxt = ILLEGAL;
        endcase
      end
      MEMADR:  nxt = (Opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      MEMWB:   nxt = FETCH;
      MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
      EXEC_R:  nxt = RWB;
      RWB:     nxt = FETCH;
      BRANCH:  nxt = FETCH;
      JUMP:    nxt = FETCH;
      EXEC_I:  nxt = IWB;
      IWB:     nxt = FETCH;
      ILLEGAL: nxt = TRAP_ON_ILLEGAL ? ILLEGAL : FETCH;
      default: nxt = RST;
    endcase
  end

  // State plus all outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RST;
      pcwrite_q   <= 1'b0;
      PCWriteCond <= 1'b0;
      IorD        <= 1'b0;
      MemRead     <= 1'b0;
      memwrite_q  <= 1'b0;
      irwrite_q   <= 1'b0;
      MemtoReg    <= 1'b0;
      RegWrite    <= 1'b0;
      RegDst      <= 1'b0;
      ALUSrcA     <= 1'b0;
      ALUSrcB     <= 2'b00;
      PCSource    <= 2'b00;
      ALUOp1      <= 1'b0;
      ALUOp0      <= 1'b0;
      AluOpcode   <= 6'b000000;
      instrdone_q <= 1'b0;
      Trap        <= 1'b0;
    end else begin
      state       <= nxt;
      pcwrite_q   <= (nxt == FETCH) || (nxt == JUMP);
      PCWriteCond <= (nxt == BRANCH);
      IorD        <= (nxt == MEMRD) || (nxt == MEMWR);
      MemRead     <= (nxt == FETCH) || (nxt == MEMRD);
      memwrite_q  <= (nxt == MEMWR);
      irwrite_q   <= (nxt == FETCH);
      MemtoReg    <= (nxt == MEMWB);
      RegWrite    <= (nxt == MEMWB) || (nxt == RWB) || (nxt == IWB);
      RegDst      <= (nxt == RWB);
      ALUSrcA     <= (nxt == MEMADR) || (nxt == EXEC_R) || (nxt == BRANCH) || (nxt == EXEC_I);
      ALUSrcB     <= (nxt == FETCH)                       ? 2'b01 :
                     (nxt == DECODE)                      ? 2'b11 :
                     ((nxt == MEMADR) || (nxt == EXEC_I)) ? 2'b10 : 2'b00;
      PCSource    <= (nxt == BRANCH) ? 2'b01 :
                     (nxt == JUMP)   ? 2'b10 : 2'b00;
      ALUOp1      <= (nxt == EXEC_R);
      ALUOp0      <= (nxt == BRANCH);
      // A stale immediate opcode in IR must never reach ALUControl outside EXEC_I,
      // otherwise the PC+4 / branch-target adds in FETCH/DECODE would be corrupted.
      AluOpcode   <= (nxt == EXEC_I) ? Opcode : 6'b000000;
      instrdone_q <= (nxt == MEMWB) || (nxt == MEMWR) || (nxt == RWB) || (nxt == BRANCH) ||
                     (nxt == JUMP) || (nxt == IWB) || ((nxt == ILLEGAL) && !TRAP_ON_ILLEGAL);
      Trap        <= Trap || (nxt == ILLEGAL);
    end
  end

  // Masking only applies in the memory-access states, so JUMP's PCWrite is unaffected.
  logic mem_ok;
  assign mem_ok = mem_ready || !((state == FETCH) || (state == MEMRD) || (state == MEMWR));

  assign PCWrite   = pcwrite_q   & mem_ok;
  assign IRWrite   = irwrite_q   & mem_ok;
  assign MemWrite  = memwrite_q  & mem_ok;
  assign InstrDone = instrdone_q & mem_ok;

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
`ifdef MCC_MEM_WAIT_EN
  logic       MemReady;
`endif
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst;
  logic       ALUSrcA, ALUOp1, ALUOp0, InstrDone, Trap;
  logic [1:0] ALUSrcB, PCSource;
  logic [5:0] AluOpcode;

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode),
`ifdef MCC_MEM_WAIT_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .AluOpcode(AluOpcode), .InstrDone(InstrDone), .Trap(Trap)
  );

  // Output bundle: pcw,pcwc,iord,mr,mw,irw,m2r,rw,rd,srca,srcb[2],pcs[2],aluop[2],aluopc[6],done,trap
  logic [23:0] got;
  assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst,
                ALUSrcA, ALUSrcB, PCSource, ALUOp1, ALUOp0, AluOpcode, InstrDone, Trap};

  function automatic logic [23:0] ex(input logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, srca,
                                     input logic [1:0] srcb, pcs, aop, input logic [5:0] aopc,
                                     input logic done, trap);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, srca, srcb, pcs, aop, aopc, done, trap};
  endfunction

  localparam logic [23:0] Z       = 24'h0;
  localparam logic [23:0] E_FETCH = ex(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,6'd0,0,0);
  localparam logic [23:0] E_DEC   = ex(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,6'd0,0,0);
  localparam logic [23:0] E_EXR   = ex(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,6'd0,0,0);
  localparam logic [23:0] E_RWB   = ex(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,6'd0,1,0);
  localparam logic [23:0] E_MADR  = ex(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,6'd0,0,0);
  localparam logic [23:0] E_MRD   = ex(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,6'd0,0,0);
  localparam logic [23:0] E_MWB   = ex(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,6'd0,1,0);
  localparam logic [23:0] E_MWR   = ex(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,6'd0,1,0);
  localparam logic [23:0] E_BR    = ex(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,6'd0,1,0);
  localparam logic [23:0] E_JMP   = ex(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,6'd0,1,0);
  localparam logic [23:0] E_IWB   = ex(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,6'd0,1,0);
  localparam logic [23:0] E_ILL   = ex(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,6'd0,0,1);

  function automatic logic [23:0] e_exi(input logic [5:0] op);
    return ex(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,op,0,0);
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic [5:0] o, input logic [23:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    Opcode = 6'b000000;
`ifdef MCC_MEM_WAIT_EN
    MemReady = 1'b1;
`endif
    // reset held three cycles
    add(1, 6'b000000, Z); add(1, 6'b000000, Z); add(1, 6'b000000, Z);
    // R-type: InstrDone on cycle 4
    add(0, 6'b000000, E_FETCH); add(0, 6'b000000, E_DEC);
    add(0, 6'b000000, E_EXR);   add(0, 6'b000000, E_RWB);
    // lw: five cycles
    add(0, 6'b100011, E_FETCH); add(0, 6'b100011, E_DEC); add(0, 6'b100011, E_MADR);
    add(0, 6'b100011, E_MRD);   add(0, 6'b100011, E_MWB);
    // andi (001100): AluOpcode only in EXEC_I
    add(0, 6'b001100, E_FETCH); add(0, 6'b001100, E_DEC);
    add(0, 6'b001100, e_exi(6'b001100)); add(0, 6'b001100, E_IWB);
    // sw
    add(0, 6'b101011, E_FETCH); add(0, 6'b101011, E_DEC); add(0, 6'b101011, E_MADR);
    add(0, 6'b101011, E_MWR);
    // beq: three cycles
    add(0, 6'b000100, E_FETCH); add(0, 6'b000100, E_DEC); add(0, 6'b000100, E_BR);
    // j
    add(0, 6'b000010, E_FETCH); add(0, 6'b000010, E_DEC); add(0, 6'b000010, E_JMP);
    // slti and addi
    add(0, 6'b001010, E_FETCH); add(0, 6'b001010, E_DEC);
    add(0, 6'b001010, e_exi(6'b001010)); add(0, 6'b001010, E_IWB);
    add(0, 6'b001000, E_FETCH); add(0, 6'b001000, E_DEC);
    add(0, 6'b001000, e_exi(6'b001000)); add(0, 6'b001000, E_IWB);
    // reset in the middle of lw: no MEMRD/MEMWB after release
    add(0, 6'b100011, E_FETCH); add(0, 6'b100011, E_DEC); add(0, 6'b100011, E_MADR);
    add(1, 6'b100011, Z);       add(0, 6'b100011, E_FETCH); add(0, 6'b100011, E_DEC);
    add(0, 6'b100011, E_MADR);  add(0, 6'b100011, E_MRD);   add(0, 6'b100011, E_MWB);
    // illegal opcode: sticky trap, stuck until reset
    add(0, 6'b111111, E_FETCH); add(0, 6'b111111, E_DEC); add(0, 6'b111111, E_ILL);
    add(0, 6'b000000, E_ILL);   add(0, 6'b000000, E_ILL);
    add(1, 6'b000000, Z);       add(0, 6'b000000, E_FETCH);

    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      Opcode = vecs[i].op;
      tick();
      check("vec", i, vecs[i].exp);
    end

    // Asynchronous reset mid EXEC_R: outputs clear before any clock edge.
    Opcode = 6'b000000;
    tick(); check("seq_dec", 0, E_DEC);
    tick(); check("seq_exr", 1, E_EXR);
    reset = 1'b1;
    #1; check("async_rst", 2, Z);
    tick(); check("rst_held", 3, Z);
    reset = 1'b0;
    #1; check("rst_state_before_edge", 4, Z);
    tick(); check("first_fetch", 5, E_FETCH);

`ifdef MCC_MEM_WAIT_EN
    // Memory wait in FETCH: PCWrite/IRWrite masked, MemRead held.
    MemReady = 1'b0;
    #1; check("wait_mask", 6, ex(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,6'd0,0,0));
    for (int k = 0; k < 3; k++) begin
      tick(); check("wait_hold", 7 + k, ex(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,6'd0,0,0));
    end
    MemReady = 1'b1;
    #1; check("wait_release", 10, E_FETCH);
    tick(); check("wait_decode", 11, E_DEC);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
